// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared helpers for the NoC link relay: stored flit width
//                and the receive-FIFO credit margin.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

  // A stored flit carries {last, addr, data}.
  function automatic int flit_w(input int a_w, input int d_w);
    return a_w + d_w + 1;
  endfunction

  // Free FIFO slots needed before credit is granted. When credit drops,
  // up to STAGES beats sit in the forward pipe and STAGES more can still be
  // accepted while the ready bit walks the reverse pipe; one extra slot
  // covers the beat accepted on the edge the count was sampled.
  function automatic int credit_margin(input int stages);
    return 2 * stages + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_relay_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : noc_relay_fifo
//  Description : First-word fall-through synchronous FIFO with explicit
//                pointer wrap (any DEPTH), occupancy count and a sticky
//                overflow flag.
//  Ports       : clk, rst_n        clock, async active-low reset
//                push, wdata       write request and data
//                pop               read request (ignored when empty)
//                rdata             head entry, valid whenever !empty
//                count, empty      occupancy and empty flag
//                overflow          sticky: write attempted while full
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_relay_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             overflow
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w-1:0] c_last_idx = c_ptr_w'(DEPTH - 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
    return (p == c_last_idx) ? '0 : p + 1'b1;
  endfunction

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = pop & ~w_empty;
  // A pop in the same cycle frees the head slot, so a full FIFO still
  // accepts the write.
  assign w_do_push = push & (~w_full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (push & ~w_do_push) r_overflow <= 1'b1;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata    = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign empty    = w_empty;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/noc_link_relay.sv
`default_nettype none
// ============================================================================
//  Module      : noc_link_relay
//  Description : Retiming link stage between two NoC switches. STAGES
//                forward registers carry {valid,last,addr+data}, STAGES
//                reverse registers carry ready; a receive FWFT FIFO sized
//                for the full round trip absorbs every in-flight beat.
//  Ports       : clk, rst_n                 clock, async active-low reset
//                s_axis_wdata/wvalid/wlast  upstream flit
//                s_axis_wready              delayed credit to upstream
//                m_axis_wdata/wvalid/wlast  downstream flit (FIFO head)
//                m_axis_wready              downstream accept
//                occupancy                  receive FIFO count
//                overflow                   sticky write-while-full flag
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_link_relay
  import noc_pkg::*;
#(
  parameter int A_W    = 3,
  parameter int D_W    = 32,
  parameter int STAGES = 4,
  parameter int DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [A_W+D_W-1:0]           s_axis_wdata,
  input  logic                         s_axis_wvalid,
  input  logic                         s_axis_wlast,
  output logic                         s_axis_wready,
  output logic [A_W+D_W-1:0]           m_axis_wdata,
  output logic                         m_axis_wvalid,
  output logic                         m_axis_wlast,
  input  logic                         m_axis_wready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         overflow
);

  localparam int c_flit_w = flit_w(A_W, D_W);
  localparam int c_cnt_w  = $clog2(DEPTH + 1);
  localparam int c_margin = credit_margin(STAGES);

  if (STAGES < 1) begin : g_check_stages
    $error("noc_link_relay: STAGES must be at least 1");
  end
  if (DEPTH < c_margin + 1) begin : g_check_depth
    $error("noc_link_relay: DEPTH must be at least 2*STAGES+2");
  end

  logic [STAGES-1:0]   r_fwd_vld;
  logic [c_flit_w-1:0] r_fwd_flit [STAGES];
  logic [STAGES-1:0]   r_rdy_pipe;

  logic                w_accept;
  logic                w_pop;
  logic                w_empty;
  logic [c_cnt_w-1:0]  w_count;
  logic [c_cnt_w-1:0]  w_free;
  logic                w_credit_ok;
  logic [c_flit_w-1:0] w_rd_flit;

  assign w_accept      = s_axis_wvalid & s_axis_wready;
  assign s_axis_wready = r_rdy_pipe[STAGES-1];

  // Credit is judged on the registered count only, so the reverse pipe
  // starts from a clean flop and never sees the pop path combinationally.
  assign w_free      = c_cnt_w'(DEPTH) - w_count;
  assign w_credit_ok = (w_free >= c_cnt_w'(c_margin));

  // Control pipes: shift every cycle, no stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_vld  <= '0;
      r_rdy_pipe <= '0;
    end else begin
      r_fwd_vld[0]  <= w_accept;
      r_rdy_pipe[0] <= w_credit_ok;
      for (int i = 1; i < STAGES; i++) begin
        r_fwd_vld[i]  <= r_fwd_vld[i-1];
        r_rdy_pipe[i] <= r_rdy_pipe[i-1];
      end
    end
  end

  // Payload travels alongside the valid bit and needs no reset.
  always_ff @(posedge clk) begin
    r_fwd_flit[0] <= {s_axis_wlast, s_axis_wdata};
    for (int i = 1; i < STAGES; i++) begin
      r_fwd_flit[i] <= r_fwd_flit[i-1];
    end
  end

  assign w_pop = m_axis_wvalid & m_axis_wready;

  noc_relay_fifo #(
    .WIDTH (c_flit_w),
    .DEPTH (DEPTH),
    .CNT_W (c_cnt_w)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (r_fwd_vld[STAGES-1]),
    .wdata    (r_fwd_flit[STAGES-1]),
    .pop      (w_pop),
    .rdata    (w_rd_flit),
    .count    (w_count),
    .empty    (w_empty),
    .overflow (overflow)
  );

  assign m_axis_wvalid = ~w_empty;
  assign m_axis_wlast  = w_rd_flit[c_flit_w-1];
  assign m_axis_wdata  = w_rd_flit[c_flit_w-2:0];
  assign occupancy     = w_count;

endmodule
`default_nettype wire

// File: tb/tb_noc_link_relay.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_noc_link_relay
//  Description : Self-checking bench for noc_link_relay. A STAGES=4/DEPTH=16
//                instance covers reset, a cycle-exact vector table, streaming,
//                full stall, random traffic and mid-run reset; a STAGES=1/
//                DEPTH=4 instance covers the minimum configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_link_relay;

  localparam int A_W = 3;
  localparam int D_W = 32;
  localparam int FW  = A_W + D_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance
  logic [FW-1:0] s_data, m_data;
  logic          s_valid, s_last, s_ready;
  logic          m_valid, m_last, m_ready;
  logic [4:0]    occ;
  logic          ovf;

  // Minimum-configuration instance
  logic [FW-1:0] b_s_data, b_m_data;
  logic          b_s_valid, b_s_last, b_s_ready;
  logic          b_m_valid, b_m_last, b_m_ready;
  logic [2:0]    b_occ;
  logic          b_ovf;

  noc_link_relay #(.A_W(A_W), .D_W(D_W), .STAGES(4), .DEPTH(16)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_wdata  (s_data),
    .s_axis_wvalid (s_valid),
    .s_axis_wlast  (s_last),
    .s_axis_wready (s_ready),
    .m_axis_wdata  (m_data),
    .m_axis_wvalid (m_valid),
    .m_axis_wlast  (m_last),
    .m_axis_wready (m_ready),
    .occupancy     (occ),
    .overflow      (ovf)
  );

  noc_link_relay #(.A_W(A_W), .D_W(D_W), .STAGES(1), .DEPTH(4)) u_dut_min (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_wdata  (b_s_data),
    .s_axis_wvalid (b_s_valid),
    .s_axis_wlast  (b_s_last),
    .s_axis_wready (b_s_ready),
    .m_axis_wdata  (b_m_data),
    .m_axis_wvalid (b_m_valid),
    .m_axis_wlast  (b_m_last),
    .m_axis_wready (b_m_ready),
    .occupancy     (b_occ),
    .overflow      (b_ovf)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_max(input string name, input int act, input int limit);
    n_chk++;
    if (act > limit) begin
      n_fail++;
      $display("FAIL %s: got %0d, limit %0d", name, act, limit);
    end
  endtask

  // ---------------- scoreboard for the main instance ----------------
  logic [FW:0] sb_q[$];
  int          acc_cnt = 0;
  int          out_cnt = 0;
  int          cyc_n   = 0;
  logic        obs_acc, obs_mv, obs_ml, obs_sr;
  int          obs_occ;

  // Called at the falling edge: inputs and registered outputs are stable and
  // equal to what the next rising edge will act on.
  task automatic observe();
    obs_acc = s_valid & s_ready;
    obs_mv  = m_valid;
    obs_ml  = m_last;
    obs_sr  = s_ready;
    obs_occ = int'(occ);
    if (s_valid && s_ready) begin
      sb_q.push_back({s_last, s_data});
      acc_cnt++;
    end
    if (m_valid && m_ready) begin
      out_cnt++;
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_extra_beat: got 0x%0h, expected no beat", {m_last, m_data});
      end else begin
        chk("sb_beat", 64'({m_last, m_data}), 64'(sb_q.pop_front()));
      end
    end
  endtask

  // One clock cycle: drive at rising+1, observe at falling, return at rising+1.
  task automatic cycle(input logic sv, input logic sl, input logic [FW-1:0] sd, input logic mr);
    s_valid = sv;
    s_last  = sl;
    s_data  = sd;
    m_ready = mr;
    @(negedge clk);
    observe();
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    b_s_valid = 1'b0; b_s_last = 1'b0; b_s_data = '0; b_m_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        sv;
    logic        sl;
    logic [31:0] sd;
    logic        mr;
    logic        e_sr;
    logic        e_mv;
    logic [4:0]  e_occ;
    logic        e_chk;
    logic [31:0] e_d;
    logic        e_l;
  } vec_t;

  function automatic vec_t mk(input logic sv, input logic sl, input logic [31:0] sd,
                              input logic mr, input logic e_sr, input logic e_mv,
                              input logic [4:0] e_occ, input logic e_chk,
                              input logic [31:0] e_d, input logic e_l);
    vec_t v;
    v.sv = sv; v.sl = sl; v.sd = sd; v.mr = mr; v.e_sr = e_sr; v.e_mv = e_mv;
    v.e_occ = e_occ; v.e_chk = e_chk; v.e_d = e_d; v.e_l = e_l;
    return v;
  endfunction

  vec_t tbl [14];

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k, first_acc, first_vld, run, lasts, peak, occ7, rdy_up;
    int acc0, out0, b_k, b_exp, b_peak;
    logic run_done, saw_drop, b_saw_drop;

    // Entry n (index n-1) is applied before the n-th rising edge after reset
    // release and checked just after it. Beat bN is the one driven in entry N.
    //            sv sl  sd        mr sr mv occ chk e_d       e_l
    tbl[0]  = mk(1, 0, 32'h101, 1, 0, 0, 0, 0, 32'h0,   0);
    tbl[1]  = mk(1, 0, 32'h102, 1, 0, 0, 0, 0, 32'h0,   0);
    tbl[2]  = mk(1, 0, 32'h103, 1, 0, 0, 0, 0, 32'h0,   0);
    tbl[3]  = mk(1, 0, 32'h104, 1, 1, 0, 0, 0, 32'h0,   0);  // ready at 4th edge
    tbl[4]  = mk(1, 0, 32'h105, 1, 1, 0, 0, 0, 32'h0,   0);  // b5 accepted
    tbl[5]  = mk(1, 0, 32'h106, 1, 1, 0, 0, 0, 32'h0,   0);
    tbl[6]  = mk(1, 1, 32'h107, 1, 1, 0, 0, 0, 32'h0,   0);  // b7 carries last
    tbl[7]  = mk(1, 0, 32'h108, 1, 1, 0, 0, 0, 32'h0,   0);
    tbl[8]  = mk(1, 0, 32'h109, 1, 1, 1, 1, 1, 32'h105, 0);  // b5 written
    tbl[9]  = mk(1, 0, 32'h10a, 1, 1, 1, 1, 1, 32'h106, 0);  // push b6, pop b5
    tbl[10] = mk(1, 0, 32'h10b, 0, 1, 1, 2, 1, 32'h106, 0);  // consumer stalls
    tbl[11] = mk(1, 0, 32'h10c, 0, 1, 1, 3, 1, 32'h106, 0);
    tbl[12] = mk(1, 0, 32'h10d, 1, 1, 1, 3, 1, 32'h107, 1);  // head b7, last
    tbl[13] = mk(0, 0, 32'h10e, 1, 1, 1, 3, 1, 32'h108, 0);

    // ---------------- reset values ----------------
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_occupancy", 64'(occ), 64'(0));
    chk("rst_overflow", 64'(ovf), 64'(0));
    chk("rst_min_s_ready", 64'(b_s_ready), 64'(0));
    rst_n = 1'b1;

    // ---------------- cycle-exact table ----------------
    for (int i = 0; i < 14; i++) begin
      s_valid = tbl[i].sv;
      s_last  = tbl[i].sl;
      s_data  = {3'd3, tbl[i].sd};
      m_ready = tbl[i].mr;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_s_ready", i + 1), 64'(s_ready), 64'(tbl[i].e_sr));
      chk($sformatf("tbl%0d_m_valid", i + 1), 64'(m_valid), 64'(tbl[i].e_mv));
      chk($sformatf("tbl%0d_occupancy", i + 1), 64'(occ), 64'(tbl[i].e_occ));
      if (tbl[i].e_chk) begin
        chk($sformatf("tbl%0d_m_data", i + 1), 64'(m_data), 64'({3'd3, tbl[i].e_d}));
        chk($sformatf("tbl%0d_m_last", i + 1), 64'(m_last), 64'(tbl[i].e_l));
      end
    end

    // ---------------- 20-beat back-to-back stream ----------------
    do_reset();
    acc0 = acc_cnt; out0 = out_cnt;
    first_acc = -1; first_vld = -1; run = 0; lasts = 0; run_done = 1'b0;
    for (int c = 0; c < 200 && (out_cnt - out0) < 20; c++) begin
      k = acc_cnt - acc0;
      cycle(1'(k < 20), 1'(k == 19), {3'd3, 32'(k + 1)}, 1'b1);
      if (obs_acc && first_acc < 0) first_acc = cyc_n;
      if (obs_mv) begin
        if (first_vld < 0) first_vld = cyc_n;
        if (!run_done) run++;
        if (obs_ml) lasts++;
      end else if (first_vld >= 0) begin
        run_done = 1'b1;
      end
    end
    chk("stream_latency_cycles", 64'(first_vld - first_acc), 64'(5));
    chk("stream_consecutive_valid", 64'(run), 64'(20));
    chk("stream_beats_out", 64'(out_cnt - out0), 64'(20));
    chk("stream_last_count", 64'(lasts), 64'(1));

    // ---------------- full stall then drain ----------------
    acc0 = acc_cnt; out0 = out_cnt;
    peak = 0; saw_drop = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cycle(1'b1, 1'b0, {3'd3, 32'h200 + 32'(c)}, 1'b0);
      if (obs_occ > peak) peak = obs_occ;
      if (!obs_sr) saw_drop = 1'b1;
    end
    chk("stall_s_ready_dropped", 64'(saw_drop), 64'(1));
    chk("stall_s_ready_now", 64'(s_ready), 64'(0));
    chk_max("stall_peak_occupancy", peak, 16);
    chk("stall_overflow", 64'(ovf), 64'(0));
    occ7 = -1; rdy_up = -1;
    for (int c = 0; c < 200; c++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      if (obs_occ <= 7 && occ7 < 0) occ7 = cyc_n;
      if (obs_sr && rdy_up < 0) rdy_up = cyc_n;
      if (obs_occ == 0 && rdy_up >= 0 && !obs_mv) break;
    end
    chk("drain_all_beats", 64'(out_cnt - out0), 64'(acc_cnt - acc0));
    chk("drain_queue_empty", 64'(sb_q.size()), 64'(0));
    chk("drain_credit_recovery", 64'(rdy_up - occ7), 64'(4));

    // ---------------- random traffic ----------------
    acc0 = acc_cnt; out0 = out_cnt;
    for (int c = 0; c < 80000 && (out_cnt - out0) < 10000; c++) begin
      k = acc_cnt - acc0;
      cycle((k < 10000) ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)),
            {3'($urandom_range(0, 7)), 32'($urandom)}, 1'($urandom_range(0, 1)));
    end
    chk("random_beats_in", 64'(acc_cnt - acc0), 64'(10000));
    chk("random_beats_out", 64'(out_cnt - out0), 64'(10000));
    chk("random_queue_empty", 64'(sb_q.size()), 64'(0));
    chk("random_overflow", 64'(ovf), 64'(0));

    // ---------------- reset with beats in flight and stored ----------------
    for (int c = 0; c < 50; c++) begin
      cycle(1'b1, 1'b0, {3'd3, 32'h300 + 32'(c)}, 1'b0);
      if (obs_occ >= 5) break;
    end
    chk("midrst_fifo_loaded", 64'(occ >= 5), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", 64'(m_valid), 64'(0));
    chk("midrst_occupancy", 64'(occ), 64'(0));
    chk("midrst_s_ready", 64'(s_ready), 64'(0));
    sb_q.delete();
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc0 = acc_cnt; out0 = out_cnt;
    for (int c = 0; c < 60; c++) begin
      k = acc_cnt - acc0;
      cycle(1'(k < 3), 1'(k == 2), {3'd5, 32'h4a1 + 32'(k)}, 1'b1);
    end
    chk("midrst_beats_in", 64'(acc_cnt - acc0), 64'(3));
    chk("midrst_beats_out", 64'(out_cnt - out0), 64'(3));
    chk("midrst_queue_empty", 64'(sb_q.size()), 64'(0));

    // ---------------- minimum configuration: STAGES=1, DEPTH=4 ----------------
    b_k = 0; b_exp = 0; b_peak = 0; b_saw_drop = 1'b0;
    for (int c = 0; c < 20; c++) begin
      b_s_valid = 1'b1;
      b_s_last  = 1'b0;
      b_s_data  = {3'd1, 32'h500 + 32'(b_k)};
      b_m_ready = 1'b0;
      @(negedge clk);
      if (b_s_valid && b_s_ready) b_k++;
      if (int'(b_occ) > b_peak) b_peak = int'(b_occ);
      if (!b_s_ready && c > 2) b_saw_drop = 1'b1;
      @(posedge clk);
      #1;
    end
    chk_max("min_peak_occupancy", b_peak, 4);
    chk("min_s_ready_dropped", 64'(b_saw_drop), 64'(1));
    chk("min_overflow", 64'(b_ovf), 64'(0));
    b_s_valid = 1'b0;
    b_m_ready = 1'b1;
    for (int c = 0; c < 50 && b_exp < b_k; c++) begin
      @(negedge clk);
      if (b_m_valid && b_m_ready) begin
        chk("min_beat", 64'(b_m_data), 64'({3'd1, 32'h500 + 32'(b_exp)}));
        b_exp++;
      end
      @(posedge clk);
      #1;
    end
    chk("min_drained", 64'(b_exp), 64'(b_k));
    chk("min_final_occupancy", 64'(b_occ), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
